// File: rtl/decoder_3to8.sv
// Purpose : registered 3-to-8 one-hot decoder with enable and selectable output polarity.
// Latency : one core clock; en/d sampled at edge N appear on y/valid right after edge N.
// Backpressure: none; accepts a new select every cycle and never stalls.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous, active-high reset (outputs go inactive at once)
//   en    - decode enable, sampled on clk
//   d     - 3-bit binary select, sampled on clk
//   y     - registered decode, bit i set (or cleared when OUT_ACTIVE_LOW) for d == i
//   valid - registered copy of en
module decoder_3to8 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] d,
    output logic [7:0] y,
    output logic       valid
);

    // Inactive output pattern; also the polarity mask applied to the one-hot code.
    localparam logic [7:0] Y_IDLE = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0] w_onehot;
    logic [7:0] w_y_next;
    logic [7:0] r_y;
    logic       r_valid;

    always_comb begin
        w_onehot = 8'h00;
        if (en) begin
            w_onehot[d] = 1'b1;
        end
        // XOR with the idle pattern inverts the whole word for active-low use,
        // so the disabled state naturally lands on Y_IDLE as well.
        w_y_next = w_onehot ^ Y_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= Y_IDLE;
            r_valid <= 1'b0;
        end else begin
            r_y     <= w_y_next;
            r_valid <= en;
        end
    end

    // Outputs come straight from flops: no combinational input-to-output path.
    assign y     = r_y;
    assign valid = r_valid;

endmodule

// File: tb/tb_decoder_3to8.sv
// Purpose : directed and random checking of decoder_3to8 in both output polarities.
// Latency : expects each sample on y/valid one clock after it is presented.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_decoder_3to8;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       en;
    logic [2:0] d;
    logic [7:0] y_hi;
    logic [7:0] y_lo;
    logic       valid_hi;
    logic       valid_lo;

    int n_checks;
    int n_fail;

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .d     (d),
        .y     (y_hi),
        .valid (valid_hi)
    );

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .d     (d),
        .y     (y_lo),
        .valid (valid_lo)
    );

    // Clock is held low until clk_run is set, so reset can be checked with no edges.
    initial clk = 1'b0;
    always #5 clk = clk_run ? ~clk : clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Expected active-high code from the reference expression.
    function automatic logic [7:0] ref_hi(input logic e, input logic [2:0] dd);
        logic [7:0] one;
        one = 8'h01;
        return e ? (one << dd) : 8'h00;
    endfunction

    // Check both instances against one expected active-high value.
    task automatic check_out(input string tag, input logic [7:0] exp_hi, input logic exp_vld);
        check_val({tag, "_y_hi"}, y_hi, exp_hi);
        check_val({tag, "_y_lo"}, y_lo, ~exp_hi);
        check_val({tag, "_vld_hi"}, {7'd0, valid_hi}, {7'd0, exp_vld});
        check_val({tag, "_vld_lo"}, {7'd0, valid_lo}, {7'd0, exp_vld});
    endtask

    // Present en/d, let one rising edge sample them, then check 1 time unit later.
    task automatic step(input string tag, input logic e, input logic [2:0] dd, input logic [7:0] exp_hi);
        en = e;
        d  = dd;
        @(posedge clk);
        #1;
        check_out(tag, exp_hi, e);
    endtask

    // Hand-computed decode table for the sweep.
    logic [7:0] sweep_tbl [8];
    initial begin
        sweep_tbl[0] = 8'h01; sweep_tbl[1] = 8'h02;
        sweep_tbl[2] = 8'h04; sweep_tbl[3] = 8'h08;
        sweep_tbl[4] = 8'h10; sweep_tbl[5] = 8'h20;
        sweep_tbl[6] = 8'h40; sweep_tbl[7] = 8'h80;
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk_run  = 1'b0;
        rst      = 1'b0;
        en       = 1'b1;
        d        = 3'd6;

        // Asynchronous reset with the clock stopped.
        #1;
        rst = 1'b1;
        #1;
        check_out("rst_noclk", 8'h00, 1'b0);

        // Release reset, then the first edge decodes d = 0.
        rst = 1'b0;
        clk_run = 1'b1;
        step("first", 1'b1, 3'd0, 8'h01);

        // Full sweep, one-hot every cycle.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("sweep%0d", i), 1'b1, 3'(i), sweep_tbl[i]);
            check_val($sformatf("onehot%0d", i), 8'($countones(y_hi)), 8'd1);
        end

        // Enable gating: disabled output, then re-enable.
        step("en_off", 1'b0, 3'd5, 8'h00);
        step("en_on", 1'b1, 3'd5, 8'h20);
        step("en_fall", 1'b0, 3'd5, 8'h00);

        // Mid-stream reset during a sweep at d = 4.
        step("pre_rst3", 1'b1, 3'd3, 8'h08);
        step("pre_rst4", 1'b1, 3'd4, 8'h10);
        en = 1'b1;
        d  = 3'd5;
        rst = 1'b1;
        #1;
        check_out("rst_mid", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_hold", 8'h00, 1'b0);
        rst = 1'b0;
        for (int i = 5; i < 8; i++) begin
            step($sformatf("resume%0d", i), 1'b1, 3'(i), sweep_tbl[i]);
        end

        // Explicit polarity points on the active-low instance.
        step("pol_on", 1'b1, 3'd3, 8'h08);
        check_val("pol_f7", y_lo, 8'hF7);
        step("pol_off", 1'b0, 3'd3, 8'h00);
        check_val("pol_ff", y_lo, 8'hFF);

        // Random en/d against the reference expression.
        for (int i = 0; i < 1000; i++) begin
            logic       re;
            logic [2:0] rd;
            re = 1'($urandom_range(0, 1));
            rd = 3'($urandom_range(0, 7));
            step("rand", re, rd, ref_hi(re, rd));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
